// File: rtl/if_id_stage.sv
// IF/ID stage: two-entry skid buffer between fetch and decode.
// Holds fetched instr+PC and slices the main entry into decode fields.
module if_id_stage #(
   parameter int unsigned          DATA_W    = 32,
   parameter logic [DATA_W-1:0]    NOP_INSTR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [DATA_W-1:0] in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_instr,
   output logic [5:0]        out_opcode,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_rd,
   output logic [4:0]        out_shamt,
   output logic [5:0]        out_funct,
   output logic [15:0]       out_imm
);

   typedef struct packed {
      logic              v;
      logic [DATA_W-1:0] instr;
      logic [DATA_W-1:0] pc;
   } ent_t;

   ent_t main_q, main_d;
   ent_t skid_q, skid_d;
   logic rdy_q, rdy_d;

   logic accept;
   logic deliver;
   logic main_free;

   assign accept    = in_valid & rdy_q;
   assign deliver   = main_q.v & out_ready;
   assign main_free = ~main_q.v | deliver;

   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (flush) begin
         // Dropping both valids is enough; a same-cycle accept is lost too.
         main_d.v = 1'b0;
         skid_d.v = 1'b0;
      end else if (main_free) begin
         if (skid_q.v) begin
            main_d   = skid_q;
            skid_d.v = 1'b0;
         end else if (accept) begin
            main_d.v     = 1'b1;
            main_d.instr = in_instr;
            main_d.pc    = in_pc;
         end else begin
            main_d.v = 1'b0;
         end
      end else if (accept) begin
         skid_d.v     = 1'b1;
         skid_d.instr = in_instr;
         skid_d.pc    = in_pc;
      end
      rdy_d = ~skid_d.v;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q <= '{v: 1'b0, instr: NOP_INSTR, pc: '0};
         skid_q <= '{v: 1'b0, instr: NOP_INSTR, pc: '0};
         rdy_q  <= 1'b0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
         rdy_q  <= rdy_d;
      end
   end

   logic [DATA_W-1:0] dec;

   // Invalid slot decodes as a bubble so ID never sees stale fields.
   assign dec        = main_q.v ? main_q.instr : NOP_INSTR;
   assign in_ready   = rdy_q;
   assign out_valid  = main_q.v;
   assign out_pc     = main_q.pc;
   assign out_instr  = dec;
   assign out_opcode = dec[31:26];
   assign out_rs     = dec[25:21];
   assign out_rt     = dec[20:16];
   assign out_rd     = dec[15:11];
   assign out_shamt  = dec[10:6];
   assign out_funct  = dec[5:0];
   assign out_imm    = dec[15:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: FIFO-level reference model plus directed vectors.
// Model compared every cycle; literal expectations pin the model.
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [5:0]  out_opcode;
   logic [4:0]  out_rs;
   logic [4:0]  out_rt;
   logic [4:0]  out_rd;
   logic [4:0]  out_shamt;
   logic [5:0]  out_funct;
   logic [15:0] out_imm;

   if_id_stage #(.DATA_W(32), .NOP_INSTR(32'h0)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr),
      .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
      .out_rd(out_rd), .out_shamt(out_shamt), .out_funct(out_funct),
      .out_imm(out_imm)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: a 2-deep FIFO; ready means fewer than two held.
   typedef struct {
      logic [31:0] i;
      logic [31:0] p;
   } ent_t;

   ent_t        mq[$];
   logic        m_rdy = 1'b0;
   logic [31:0] m_pc = '0;
   bit          m_on = 1'b0;

   always @(posedge clk) begin
      bit acc, dlv;
      acc = in_valid && m_rdy;
      dlv = (mq.size() > 0) && out_ready;
      if (rst) begin
         mq.delete();
         m_rdy = 1'b0;
         m_pc  = '0;
         m_on  = 1'b1;
      end else if (flush) begin
         mq.delete();
         m_rdy = 1'b1;
      end else begin
         if (dlv) void'(mq.pop_front());
         if (acc) mq.push_back('{i: in_instr, p: in_pc});
         m_rdy = (mq.size() < 2);
      end
      if (mq.size() > 0) m_pc = mq[0].p;
   end

   logic [31:0] dlog[$];

   always @(negedge clk) begin
      logic [31:0] w;
      if (m_on) begin
         w = (mq.size() > 0) ? mq[0].i : 32'h0;
         chk("mdl_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
         chk("mdl_ready", {31'b0, in_ready}, {31'b0, m_rdy});
         chk("mdl_pc", out_pc, m_pc);
         chk("mdl_opcode", {26'b0, out_opcode}, (w >> 26) & 32'h3F);
         chk("mdl_rs", {27'b0, out_rs}, (w >> 21) & 32'h1F);
         chk("mdl_rt", {27'b0, out_rt}, (w >> 16) & 32'h1F);
         chk("mdl_rd", {27'b0, out_rd}, (w >> 11) & 32'h1F);
         chk("mdl_shamt", {27'b0, out_shamt}, (w >> 6) & 32'h1F);
         chk("mdl_funct", {26'b0, out_funct}, w & 32'h3F);
         chk("mdl_imm", {16'b0, out_imm}, w & 32'hFFFF);
         if (mq.size() > 0) chk("mdl_instr", out_instr, w);
         if (out_valid === 1'b1 && out_ready) dlog.push_back(out_instr);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] i,
                        input logic [31:0] p);
      in_valid = v;
      in_instr = i;
      in_pc    = p;
   endtask

   task automatic chk_log(input string name, input logic [31:0] exp[$]);
      chk({name, "_cnt"}, dlog.size(), exp.size());
      for (int k = 0; k < exp.size() && k < dlog.size(); k++)
         chk(name, dlog[k], exp[k]);
   endtask

   localparam logic [31:0] A = 32'h2001_0001;
   localparam logic [31:0] B = 32'h2002_0002;
   localparam logic [31:0] C = 32'h2003_0003;
   localparam logic [31:0] D = 32'h2004_0004;

   initial begin
      logic [31:0] exp[$];

      // 1: reset for two edges
      rst = 1'b1;
      step();
      chk("rst_valid0", {31'b0, out_valid}, 32'd0);
      chk("rst_ready0", {31'b0, in_ready}, 32'd0);
      step();
      chk("rst_valid1", {31'b0, out_valid}, 32'd0);
      chk("rst_ready1", {31'b0, in_ready}, 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      rst = 1'b0;
      step();
      chk("post_rst_ready", {31'b0, in_ready}, 32'd1);

      // 2: single load word decode
      out_ready = 1'b1;
      drive(1'b1, 32'h8C22FFFC, 32'h100);
      step();
      drive(1'b0, '0, '0);
      chk("t2_valid", {31'b0, out_valid}, 32'd1);
      chk("t2_opcode", {26'b0, out_opcode}, 32'h23);
      chk("t2_rs", {27'b0, out_rs}, 32'd1);
      chk("t2_rt", {27'b0, out_rt}, 32'd2);
      chk("t2_rd", {27'b0, out_rd}, 32'd31);
      chk("t2_shamt", {27'b0, out_shamt}, 32'd31);
      chk("t2_funct", {26'b0, out_funct}, 32'h3C);
      chk("t2_imm", {16'b0, out_imm}, 32'hFFFC);
      chk("t2_pc", out_pc, 32'h100);
      step();
      chk("t2_drain", {31'b0, out_valid}, 32'd0);
      chk("t2_pc_hold", out_pc, 32'h100);

      // 3: eight back-to-back at full rate
      dlog.delete();
      exp.delete();
      for (int n = 0; n < 8; n++) begin
         drive(1'b1, 32'h1000_0000 + n, 32'h200 + 4 * n);
         exp.push_back(32'h1000_0000 + n);
         step();
         chk("t3_ready", {31'b0, in_ready}, 32'd1);
         chk("t3_valid", {31'b0, out_valid}, 32'd1);
         chk("t3_instr", out_instr, 32'h1000_0000 + n);
      end
      drive(1'b0, '0, '0);
      step();
      chk("t3_empty", {31'b0, out_valid}, 32'd0);
      chk_log("t3_order", exp);

      // 4: backpressure fills skid, C waits at fetch
      dlog.delete();
      out_ready = 1'b0;
      drive(1'b1, A, 32'h300);
      step();
      drive(1'b1, B, 32'h304);
      step();
      drive(1'b1, C, 32'h308);
      step();
      chk("t4_main", out_instr, A);
      chk("t4_full", {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      step();
      chk("t4_b", out_instr, B);
      step();
      chk("t4_c", out_instr, C);
      drive(1'b0, '0, '0);
      step();
      chk("t4_empty", {31'b0, out_valid}, 32'd0);
      exp = '{A, B, C};
      chk_log("t4_order", exp);

      // 5: flush drops held entries and the incoming C
      dlog.delete();
      out_ready = 1'b0;
      drive(1'b1, A, 32'h400);
      step();
      drive(1'b1, B, 32'h404);
      step();
      drive(1'b1, C, 32'h408);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      chk("t5_valid", {31'b0, out_valid}, 32'd0);
      chk("t5_ready", {31'b0, in_ready}, 32'd1);
      out_ready = 1'b1;
      step();
      drive(1'b1, D, 32'h500);
      step();
      drive(1'b0, '0, '0);
      chk("t5_d", out_instr, D);
      chk("t5_d_pc", out_pc, 32'h500);
      step();
      exp = '{D};
      chk_log("t5_order", exp);

      // 6: reset while both entries are full
      out_ready = 1'b0;
      drive(1'b1, A, 32'h600);
      step();
      drive(1'b1, B, 32'h604);
      step();
      drive(1'b0, '0, '0);
      chk("t6_full", {31'b0, in_ready}, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_valid", {31'b0, out_valid}, 32'd0);
      chk("t6_instr", out_instr, 32'h0);
      chk("t6_opcode", {26'b0, out_opcode}, 32'd0);
      chk("t6_imm", {16'b0, out_imm}, 32'd0);
      chk("t6_pc", out_pc, 32'd0);
      step();
      chk("t6_ready", {31'b0, in_ready}, 32'd1);
      chk("t6_stay", {31'b0, out_valid}, 32'd0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
